uart_tx_serializer: RTL and testbench

UART transmit engine: the serial end of the host transmit path. It accepts a parallel byte on tx_dato_in when tx_start pulses, and shifts the frame out on tx, LSB first: start bit, data bits, optional parity bit, stop bits. Bit timing comes from a 16x oversampling baud tick (s_tick) produced by the shared baud generator. On frame completion it returns a one-cycle tx_done pulse to the interface circuit, which clears its tx_full flag.

---
 rtl/uart_tx_serializer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, D_BIT data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to compile in the parity bit (even by default, PARITY_ODD=1 for odd).
module uart_tx_serializer #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = 16
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             tx_start,
  input  logic [D_BIT-1:0] tx_dato_in,
  output logic             tx,
  output logic             tx_done,
  output logic             tx_busy
);

  localparam int S_MAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int NW    = (D_BIT > 1) ? $clog2(D_BIT) : 1;
  localparam logic [SW-1:0] OS_LAST = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(D_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           r_state, w_state;
  logic [SW-1:0]    r_s, w_s;
  logic [NW-1:0]    r_n, w_n;
  logic [D_BIT-1:0] r_b, w_b;
  logic             r_tx, w_tx;
  logic             r_done, w_done;
  logic             r_busy, w_busy;

`ifdef UART_TX_PARITY_EN
  // Parity is computed once from the accepted byte, so later input changes cannot leak in.
  logic r_par;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_par <= 1'b0;
    else if (r_state == IDLE && tx_start) r_par <= (^tx_dato_in) ^ PARITY_ODD;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_s     <= w_s;
      r_n     <= w_n;
      r_b     <= w_b;
      r_tx    <= w_tx;
      r_done  <= w_done;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_b     = r_b;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (tx_start) begin
        w_b     = tx_dato_in;
        w_s     = '0;
        w_state = START;
      end
      START: if (s_tick) begin
        if (r_s == OS_LAST) begin
          w_s     = '0;
          w_n     = '0;
          w_state = DATA;
        end else w_s = r_s + 1'b1;
      end
      DATA: if (s_tick) begin
        if (r_s == OS_LAST) begin
          w_s = '0;
          w_b = r_b >> 1;
          if (r_n == N_LAST)
`ifdef UART_TX_PARITY_EN
            w_state = PARITY;
`else
            w_state = STOP;
`endif
          else w_n = r_n + 1'b1;
        end else w_s = r_s + 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (s_tick) begin
        if (r_s == OS_LAST) begin
          w_s     = '0;
          w_state = STOP;
        end else w_s = r_s + 1'b1;
      end
`endif
      STOP: if (s_tick) begin
        if (r_s == SB_LAST) begin
          w_s     = '0;
          w_state = IDLE;
          w_done  = 1'b1;
        end else w_s = r_s + 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx is a clean flop output.
  always_comb begin
    w_tx = 1'b1;
    case (w_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_b[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx = r_par;
`endif
      default: w_tx = 1'b1;
    endcase
    w_busy = (w_state != IDLE);
  end

  assign tx      = r_tx;
  assign tx_done = r_done;
  assign tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (SB_TICK 16 and 32) checked each clk against a frame-level model.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic [1:0] start;
  logic [7:0] data;
  logic [1:0] tx_o, done_o, busy_o;
  int nchecks = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .D_BIT(8), .SB_TICK(16), .OS_TICK(16)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(1'b0)
`endif
  ) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[0]), .tx_dato_in(data),
    .tx(tx_o[0]), .tx_done(done_o[0]), .tx_busy(busy_o[0])
  );

  uart_tx_serializer #(
    .D_BIT(8), .SB_TICK(32), .OS_TICK(16)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(1'b1)
`endif
  ) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start[1]), .tx_dato_in(data),
    .tx(tx_o[1]), .tx_done(done_o[1]), .tx_busy(busy_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of bit values, one entry per OS_TICK-long bit slot.
  function automatic logic exp_tx(input int k, input logic [7:0] d, input int t);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (P == 1) q.push_back(logic'(($countones(d) % 2) ^ k));
    if (t / 16 < q.size()) return q[t / 16];
    return 1'b1;
  endfunction

  function automatic int frame_ticks(input int k);
    return (1 + 8 + P) * 16 + (k == 1 ? 32 : 16);
  endfunction

  task automatic accept(input int k, input logic [7:0] d, input bit hold);
    start[k] = 1'b1;
    data     = d;
    @(posedge clk); #1;
    if (!hold) start[k] = 1'b0;
  endtask

  // Runs from the cycle after acceptance up to the tx_done cycle, checking every clk.
  task automatic run_frame(input int k, input logic [7:0] d, input int period,
                           input int stall_at, input int stall_len, input int abort_at, input bit hold);
    int t = 0, ph = 0, stall = 0, budget = 0;
    bit stalled = 0;
    int tt = frame_ticks(k);
    forever begin
      chk($sformatf("tx[%0d] t=%0d", k, t), 32'(tx_o[k]), 32'(exp_tx(k, d, t)));
      chk($sformatf("busy[%0d] t=%0d", k, t), 32'(busy_o[k]), 32'(t < tt));
      chk($sformatf("done[%0d] t=%0d", k, t), 32'(done_o[k]), 32'(t == tt));
      if (t == tt || t == abort_at) break;
      if (!hold) begin
        start[k] = ($urandom_range(0, 7) == 0);
        data     = 8'($urandom);
      end
      if (t == stall_at && !stalled) begin
        stalled = 1;
        stall   = stall_len;
      end
      if (stall > 0) begin
        stall--;
        s_tick = 1'b0;
      end else begin
        s_tick = (ph == period - 1);
        ph     = (ph + 1) % period;
      end
      @(posedge clk); #1;
      if (s_tick) t++;
      budget++;
      if (budget > 20000) begin
        nchecks++; nerr++;
        $error("FAIL timeout[%0d] observed_ticks=%0d expected_ticks=%0d", k, t, tt);
        break;
      end
    end
    s_tick = 1'b0;
    if (!hold) start[k] = 1'b0;
  endtask

  task automatic idle_chk(input int k);
    @(posedge clk); #1;
    chk($sformatf("idle_tx[%0d]", k), 32'(tx_o[k]), 32'd1);
    chk($sformatf("idle_done[%0d]", k), 32'(done_o[k]), 32'd0);
    chk($sformatf("idle_busy[%0d]", k), 32'(busy_o[k]), 32'd0);
  endtask

  task automatic send(input int k, input logic [7:0] d, input int period, input int stall_at, input int stall_len);
    accept(k, d, 0);
    run_frame(k, d, period, stall_at, stall_len, -1, 0);
    idle_chk(k);
  endtask

  initial begin
    logic [7:0] rd;
    reset = 1'b1; s_tick = 1'b0; start = 2'b00; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_tx[%0d]", k), 32'(tx_o[k]), 32'd1);
      chk($sformatf("rst_done[%0d]", k), 32'(done_o[k]), 32'd0);
      chk($sformatf("rst_busy[%0d]", k), 32'(busy_o[k]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset asserted in the middle of data bit 3, then a clean frame.
    accept(0, 8'hA5, 0);
    run_frame(0, 8'hA5, 16, -1, 0, 16 + 3 * 16 + 5, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx_o[0]), 32'd1);
    chk("async_rst_busy", 32'(busy_o[0]), 32'd0);
    chk("async_rst_done", 32'(done_o[0]), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    idle_chk(0);
    send(0, 8'h3C, 16, -1, 0);

    send(0, 8'h55, 16, -1, 0);
    send(1, 8'h80, 16, -1, 0);

    // tx_start held high: the second frame starts one clk after tx_done.
    accept(0, 8'h01, 1);
    data = 8'h02;
    run_frame(0, 8'h01, $urandom_range(1, 4), -1, 0, -1, 1);
    @(posedge clk); #1;
    run_frame(0, 8'h02, $urandom_range(1, 4), -1, 0, -1, 0);
    idle_chk(0);

    rd = 8'($urandom);
    send(0, rd, 3, 8, 1000);

    rd = 8'($urandom);
    send(0, rd, 1, -1, 0);
    rd = 8'($urandom);
    send(1, rd, $urandom_range(1, 5), -1, 0);
    rd = 8'($urandom);
    send(1, rd, 1, $urandom_range(0, 150), $urandom_range(1, 50));

    send(0, 8'h07, 2, -1, 0);
    send(1, 8'h07, 2, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
